// File: rtl/riscv_pkg.sv
// Shared RV core definitions: ALU op encodings, opcodes, MUL sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 32;

  // ALU control encodings produced by the control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;

  // Major opcodes
  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Issue/writeback bundle between the decode stage and the MUL sequencer.
// Latency: n/a (wiring only).
// Backpressure: stall from the sequencer holds fetch/decode.
// Ports: issue side (issue_valid, alu_control, regwrite_in, rs1_data, rs2_data,
//   rd_addr, flush), control side (stall, busy), writeback side (wb_valid,
//   wb_regwrite, wb_rd, wb_data).
interface mul_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            issue_valid;
  logic [3:0]      alu_control;
  logic            regwrite_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            wb_valid;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // Front end / decode side
  modport master (
    output issue_valid, alu_control, regwrite_in, rs1_data, rs2_data, rd_addr, flush,
    input  stall, busy, wb_valid, wb_regwrite, wb_rd, wb_data
  );

  // Sequencer side
  modport slave (
    input  issue_valid, alu_control, regwrite_in, rs1_data, rs2_data, rd_addr, flush,
    output stall, busy, wb_valid, wb_regwrite, wb_rd, wb_data
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand/multiplier shift registers and accumulator.
// Latency: one partial product per step; XLEN steps for a full product.
// Backpressure: none; advances only when step is asserted.
// Ports: clk, reset, load (capture operands, clear acc), step (one iteration),
//   load_mcand/load_mplier (operands), sum (acc value after the current step).
module mul_shift_add_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] load_mcand,
  input  logic [XLEN-1:0] load_mplier,
  output logic [XLEN-1:0] sum
);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  // Exposed combinationally so the controller can capture the final product
  // on the same edge as the last step.
  assign sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= load_mcand;
      mplier <= load_mplier;
      acc    <= '0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL controller beside the single-cycle ALU; other ALU ops pass untouched.
// Latency: start in cycle T -> wb_valid in cycle T+XLEN+1, fixed regardless of operands.
// Backpressure: stall (combinational) holds fetch/decode from start through the last BUSY cycle.
// Ports: clk, reset (sync, active high), bus (mul_sequencer_if.slave: issue, flush,
//   stall/busy, writeback strobe with rd/data/regwrite).
module mul_sequencer
  import riscv_pkg::*;
#(
  parameter int         XLEN   = 32,
  parameter logic [3:0] MUL_OP = ALU_MUL
) (
  input  logic          clk,
  input  logic          reset,
  mul_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  mul_state_t      state;
  logic [CW-1:0]   count;
  logic [4:0]      rd_q;
  logic            start;
  logic            step;
  logic [XLEN-1:0] sum;

  // A MUL with regwrite clear has no architectural effect, so it is not sequenced.
  assign start = bus.issue_valid && (bus.alu_control == MUL_OP) && bus.regwrite_in &&
                 (state == IDLE) && !bus.flush;

  // Low in DONE so the held instruction retires alongside its writeback.
  assign bus.stall = start || (state == BUSY);

  assign step = (state == BUSY) && !bus.flush;

  mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .step       (step),
    .load_mcand (bus.rs1_data),
    .load_mplier(bus.rs2_data),
    .sum        (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      rd_q            <= '0;
      bus.busy        <= 1'b0;
      bus.wb_valid    <= 1'b0;
      bus.wb_regwrite <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
    end else if (bus.flush) begin
      // Abort discards the partial product; wb_rd/wb_data keep their old value.
      state           <= IDLE;
      count           <= '0;
      bus.busy        <= 1'b0;
      bus.wb_valid    <= 1'b0;
      bus.wb_regwrite <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.wb_valid    <= 1'b0;
          bus.wb_regwrite <= 1'b0;
          if (start) begin
            rd_q     <= bus.rd_addr;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          if (count == CW'(XLEN - 1)) begin
            // sum already includes the final partial product.
            state           <= DONE;
            bus.wb_valid    <= 1'b1;
            bus.wb_data     <= sum;
            bus.wb_rd       <= rd_q;
            bus.wb_regwrite <= (rd_q != 5'd0);
          end
        end
        DONE: begin
          state           <= IDLE;
          bus.busy        <= 1'b0;
          bus.wb_valid    <= 1'b0;
          bus.wb_regwrite <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          bus.busy        <= 1'b0;
          bus.wb_valid    <= 1'b0;
          bus.wb_regwrite <= 1'b0;
        end
      endcase
    end
  end

endmodule
